// File: rtl/bcd_seg_scan.sv
// ============================================================================
// Module      : bcd_seg_scan
// Description : Multiplexed 7-segment scanner for a packed BCD word with
//               prescaled digit slots, dead time, leading-zero blanking and
//               frame-aligned (tear-free) display updates.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_seg_scan #(
    parameter int DIGITS = 3,
    parameter int DIV    = 1000,
    parameter int BLANK  = 8,
    parameter int LZB    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   bcd,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done
);

    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CW-1:0] c_CNT_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] c_GAP_LAST = CW'(BLANK - 1);
    localparam logic [IW-1:0] c_IDX_LAST = IW'(DIGITS - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GAP   = 2'd1;
    localparam logic [1:0] S_DRIVE = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [4*DIGITS-1:0]   pending_q, pending_d;
    logic [4*DIGITS-1:0]   shadow_q, shadow_d;
    logic [6:0]            seg_q, seg_d;
    logic [DIGITS-1:0]     an_q, an_d;
    logic                  fd_q, fd_d;

    logic [DIGITS-1:0]     w_show;
    logic                  w_acc;
    logic [4*DIGITS-1:0]   w_frame_val;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h40;
        endcase
        return s;
    endfunction

    // A load landing on the frame-start edge goes straight into the new frame.
    assign w_frame_val = load ? bcd : pending_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shadow_d  = shadow_q;
        pending_d = load ? bcd : pending_q;
        fd_d      = 1'b0;
        if (!en) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d  = S_GAP;
                    cnt_d    = '0;
                    idx_d    = '0;
                    shadow_d = w_frame_val;
                end
                S_GAP: begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == c_GAP_LAST) begin
                        state_d = S_DRIVE;
                    end
                end
                S_DRIVE: begin
                    if (cnt_q == c_CNT_LAST) begin
                        state_d = S_GAP;
                        cnt_d   = '0;
                        if (idx_q == c_IDX_LAST) begin
                            idx_d    = '0;
                            shadow_d = w_frame_val;
                            fd_d     = 1'b1;
                        end else begin
                            idx_d = idx_q + IW'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            endcase
        end
    end

    // Walk from the MS digit down: a digit shows once any digit at or above it is non-zero.
    always_comb begin
        w_show = '0;
        w_acc  = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            w_acc     = w_acc | (shadow_d[4*i +: 4] != 4'd0);
            w_show[i] = (i == 0) || (LZB == 0) || w_acc;
        end
    end

    // Outputs are derived from the next state so they line up with the registered state.
    always_comb begin
        seg_d = '0;
        an_d  = '0;
        if (state_d == S_DRIVE) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (idx_d == IW'(i)) begin
                    an_d[i] = 1'b1;
                    if (w_show[i]) begin
                        seg_d = seg_decode(shadow_d[4*i +: 4]);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            pending_q <= '0;
            shadow_q  <= '0;
            seg_q     <= '0;
            an_q      <= '0;
            fd_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
            shadow_q  <= shadow_d;
            seg_q     <= seg_d;
            an_q      <= an_d;
            fd_q      <= fd_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_done = fd_q;

endmodule

`default_nettype wire

// File: tb/tb_bcd_seg_scan.sv
// ============================================================================
// Module      : tb_bcd_seg_scan
// Description : Directed self-checking bench for bcd_seg_scan (DIGITS=3,
//               DIV=4, BLANK=1), with a blanking and a non-blanking instance.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bcd_seg_scan;

    logic        clk;
    logic        rst;
    logic        en;
    logic        load;
    logic [11:0] bcd;
    logic [6:0]  seg, seg_nl;
    logic [2:0]  an, an_nl;
    logic        frame_done, frame_done_nl;

    int n_total = 0;
    int n_pass  = 0;

    bcd_seg_scan #(.DIGITS(3), .DIV(4), .BLANK(1), .LZB(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .load       (load),
        .bcd        (bcd),
        .seg        (seg),
        .an         (an),
        .frame_done (frame_done)
    );

    bcd_seg_scan #(.DIGITS(3), .DIV(4), .BLANK(1), .LZB(0)) dut_nl (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .load       (load),
        .bcd        (bcd),
        .seg        (seg_nl),
        .an         (an_nl),
        .frame_done (frame_done_nl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full frame: exp / exp_nl are {seg2, seg1, seg0}. Optionally pulses load
    // for one cycle starting in the gap of digit ld_digit.
    task automatic run_frame(input string tag, input logic [20:0] exp, input logic [20:0] exp_nl,
                             input bit first, input int ld_digit, input logic [11:0] ld_val);
        logic [2:0] onehot;
        for (int d = 0; d < 3; d++) begin
            onehot = 3'b001 << d;
            tick();
            check($sformatf("%s d%0d gap an", tag, d), 32'(an), 32'(3'b000));
            check($sformatf("%s d%0d gap seg", tag, d), 32'(seg), 32'(7'h00));
            check($sformatf("%s d%0d gap fd", tag, d), 32'(frame_done),
                  32'((d == 0) && !first));
            if (d == ld_digit) begin
                load = 1'b1;
                bcd  = ld_val;
            end else begin
                load = 1'b0;
            end
            for (int k = 0; k < 3; k++) begin
                tick();
                load = 1'b0;
                check($sformatf("%s d%0d c%0d an", tag, d, k), 32'(an), 32'(onehot));
                check($sformatf("%s d%0d c%0d seg", tag, d, k), 32'(seg), 32'(exp[7*d +: 7]));
                check($sformatf("%s d%0d c%0d fd", tag, d, k), 32'(frame_done), 32'(0));
                check($sformatf("%s d%0d c%0d an_nl", tag, d, k), 32'(an_nl), 32'(onehot));
                check($sformatf("%s d%0d c%0d seg_nl", tag, d, k), 32'(seg_nl),
                      32'(exp_nl[7*d +: 7]));
            end
        end
    endtask

    initial begin
        rst  = 1'b0;
        en   = 1'b0;
        load = 1'b0;
        bcd  = 12'h000;
        tick();
        tick();
        check("reset seg", 32'(seg), 32'(0));
        check("reset an", 32'(an), 32'(0));
        check("reset fd", 32'(frame_done), 32'(0));

        // 123, loaded while idle, then two frames
        rst  = 1'b1;
        load = 1'b1;
        bcd  = 12'h123;
        tick();
        check("idle an", 32'(an), 32'(0));
        load = 1'b0;
        bcd  = 12'h000;
        en   = 1'b1;
        run_frame("f123a", {7'h06, 7'h5B, 7'h4F}, {7'h06, 7'h5B, 7'h4F}, 1'b1, -1, 12'h000);
        run_frame("f123b", {7'h06, 7'h5B, 7'h4F}, {7'h06, 7'h5B, 7'h4F}, 1'b0, -1, 12'h000);

        // async reset in the middle of a drive slot
        tick();
        check("pre-rst fd", 32'(frame_done), 32'(1));
        tick();
        check("pre-rst an", 32'(an), 32'(3'b001));
        check("pre-rst seg", 32'(seg), 32'(7'h4F));
        rst = 1'b0;
        #1;
        check("async rst seg", 32'(seg), 32'(0));
        check("async rst an", 32'(an), 32'(0));
        check("async rst fd", 32'(frame_done), 32'(0));
        tick();
        tick();
        rst = 1'b1;
        run_frame("f000", {7'h00, 7'h00, 7'h3F}, {7'h3F, 7'h3F, 7'h3F}, 1'b1, 1, 12'h007);
        run_frame("f007", {7'h00, 7'h00, 7'h07}, {7'h3F, 7'h3F, 7'h07}, 1'b0, 0, 12'h070);
        run_frame("f070", {7'h00, 7'h07, 7'h3F}, {7'h3F, 7'h07, 7'h3F}, 1'b0, 2, 12'h1A5);
        run_frame("f1A5", {7'h06, 7'h40, 7'h6D}, {7'h06, 7'h40, 7'h6D}, 1'b0, 1, 12'h456);
        run_frame("f456", {7'h66, 7'h6D, 7'h7D}, {7'h66, 7'h6D, 7'h7D}, 1'b0, -1, 12'h000);

        // load coincident with the frame-start edge
        load = 1'b1;
        bcd  = 12'h789;
        run_frame("f789", {7'h07, 7'h7F, 7'h6F}, {7'h07, 7'h7F, 7'h6F}, 1'b0, -1, 12'h000);

        // en dropped during digit 2 drive
        for (int i = 0; i < 10; i++) tick();
        check("pre-en an", 32'(an), 32'(3'b100));
        check("pre-en seg", 32'(seg), 32'(7'h07));
        en = 1'b0;
        tick();
        check("en-low an", 32'(an), 32'(0));
        check("en-low seg", 32'(seg), 32'(0));
        check("en-low fd", 32'(frame_done), 32'(0));
        tick();
        check("idle2 an", 32'(an), 32'(0));
        en = 1'b1;
        run_frame("fresume", {7'h07, 7'h7F, 7'h6F}, {7'h07, 7'h7F, 7'h6F}, 1'b1, -1, 12'h000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
